// File: rtl/frog_round_scorer.sv
// frog_round_scorer
//
// Purpose:
//   Round sequencer and scorekeeper for the frog game. It takes the one-cycle
//   win pulses from the victory lights and the collision level from the
//   lane/car logic. It keeps a two-digit BCD score and a life count, and holds
//   the frog grid and the victory lights in reset between rounds. It also
//   drives seven-segment images of the score and the remaining lives.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        synchronized start key level (edge-detected internally)
//   win          one-cycle win pulse per victory light [NUM_VICTORY-1:0]
//   collision    high while the frog occupies a lit car cell
//   round_reset  high = hold frog grid and victory lights in reset
//   game_over    high while in GAME_OVER
//   score_tens   BCD tens digit of the score
//   score_ones   BCD ones digit of the score
//   lives        remaining lives, binary
//   hex_tens     active-low seven-segment image of score_tens
//   hex_ones     active-low seven-segment image of score_ones
//   hex_lives    active-low seven-segment image of lives

module frog_round_scorer #(
  parameter int NUM_VICTORY = 4,
  parameter int MAX_LIVES   = 3,
  parameter int END_DELAY   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_VICTORY-1:0] win,
  input  logic                   collision,
  output logic                   round_reset,
  output logic                   game_over,
  output logic [3:0]             score_tens,
  output logic [3:0]             score_ones,
  output logic [3:0]             lives,
  output logic [6:0]             hex_tens,
  output logic [6:0]             hex_ones,
  output logic [6:0]             hex_lives
);

  localparam int             CW         = (END_DELAY > 2) ? $clog2(END_DELAY) : 1;
  localparam logic [CW-1:0]  DELAY_LAST = CW'(END_DELAY - 1);
  localparam logic [3:0]     LIVES_INIT = 4'(MAX_LIVES);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    ROUND_END,
    GAME_OVER
  } state_t;

  state_t        state;
  logic          start_q;
  logic          start_edge;
  logic          any_win;
  logic [CW-1:0] delay_cnt;

  assign start_edge = start & ~start_q;
  // Several victory lights firing in the same cycle still count as one win.
  assign any_win    = |win;

  // Active-low segment image, bit order gfedcba; values above 9 blank out.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] img;
    case (digit)
      4'd0:    img = 7'b1000000;
      4'd1:    img = 7'b1111001;
      4'd2:    img = 7'b0100100;
      4'd3:    img = 7'b0110000;
      4'd4:    img = 7'b0011001;
      4'd5:    img = 7'b0010010;
      4'd6:    img = 7'b0000010;
      4'd7:    img = 7'b1111000;
      4'd8:    img = 7'b0000000;
      4'd9:    img = 7'b0010000;
      default: img = 7'b1111111;
    endcase
    return img;
  endfunction

  assign hex_tens  = seg7(score_tens);
  assign hex_ones  = seg7(score_ones);
  assign hex_lives = seg7(lives);

  // Round sequencer. round_reset and game_over are registered alongside the
  // state, so they always match the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      // Clearing the pending edge means treating the key as already high.
      // A key held through reset then cannot fire until it is released.
      start_q     <= 1'b1;
      delay_cnt   <= '0;
      score_tens  <= 4'd0;
      score_ones  <= 4'd0;
      lives       <= LIVES_INIT;
      round_reset <= 1'b1;
      game_over   <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state       <= PLAY;
            round_reset <= 1'b0;
          end
        end

        PLAY: begin
          // A win takes priority over a collision in the same cycle.
          if (any_win) begin
            // The score saturates at 99 instead of wrapping to 00.
            if (!(score_tens == 4'd9 && score_ones == 4'd9)) begin
              if (score_ones == 4'd9) begin
                score_ones <= 4'd0;
                score_tens <= score_tens + 4'd1;
              end else begin
                score_ones <= score_ones + 4'd1;
              end
            end
            state       <= ROUND_END;
            delay_cnt   <= '0;
            round_reset <= 1'b1;
          end else if (collision) begin
            if (lives > 4'd1) begin
              lives     <= lives - 4'd1;
              state     <= ROUND_END;
              delay_cnt <= '0;
            end else begin
              lives     <= 4'd0;
              state     <= GAME_OVER;
              game_over <= 1'b1;
            end
            round_reset <= 1'b1;
          end
        end

        ROUND_END: begin
          // Win and collision are ignored here. The grid is in reset, so
          // stale pulses must not score.
          if (delay_cnt == DELAY_LAST) begin
            state       <= PLAY;
            delay_cnt   <= '0;
            round_reset <= 1'b0;
          end else begin
            delay_cnt <= delay_cnt + 1'b1;
          end
        end

        GAME_OVER: begin
          if (start_edge) begin
            score_tens <= 4'd0;
            score_ones <= 4'd0;
            lives      <= LIVES_INIT;
            state      <= ROUND_END;
            delay_cnt  <= '0;
            game_over  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frog_round_scorer.sv
// tb_frog_round_scorer
//
// Purpose:
//   Directed self-checking bench for frog_round_scorer with the default
//   parameters (4 victory lights, 3 lives, 4-cycle end delay).
//
// Ports:
//   none (top-level bench)

module tb_frog_round_scorer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] win;
  logic       collision;
  logic       round_reset;
  logic       game_over;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic [3:0] lives;
  logic [6:0] hex_tens;
  logic [6:0] hex_ones;
  logic [6:0] hex_lives;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] SEG0 = 7'b1000000;
  localparam logic [6:0] SEG1 = 7'b1111001;
  localparam logic [6:0] SEG2 = 7'b0100100;
  localparam logic [6:0] SEG3 = 7'b0110000;
  localparam logic [6:0] SEG9 = 7'b0010000;

  frog_round_scorer #(
    .NUM_VICTORY(4),
    .MAX_LIVES  (3),
    .END_DELAY  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .win        (win),
    .collision  (collision),
    .round_reset(round_reset),
    .game_over  (game_over),
    .score_tens (score_tens),
    .score_ones (score_ones),
    .lives      (lives),
    .hex_tens   (hex_tens),
    .hex_ones   (hex_ones),
    .hex_lives  (hex_lives)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge, away from
  // the rising edge the design acts on.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One win pulse, then wait out the 4-cycle end delay back into PLAY.
  task automatic score_win();
    win = 4'b0010;
    tick(1);
    win = 4'b0000;
    tick(4);
  endtask

  // One collision pulse, then wait out the end delay.
  task automatic hit_car();
    collision = 1'b1;
    tick(1);
    collision = 1'b0;
    tick(4);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (round_reset !== 1'b1) begin errors++; $display("[TB] FAIL reset_rr: got %b want 1", round_reset); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("[TB] FAIL reset_go: got %b want 0", game_over); end
    checks++; if ({score_tens, score_ones} !== 8'h00) begin errors++; $display("[TB] FAIL reset_score: got %h want 00", {score_tens, score_ones}); end
    checks++; if (lives !== 4'd3) begin errors++; $display("[TB] FAIL reset_lives: got %0d want 3", lives); end
    checks++; if ({hex_tens, hex_ones, hex_lives} !== {SEG0, SEG0, SEG3}) begin errors++; $display("[TB] FAIL reset_hex: got %b %b %b want %b %b %b", hex_tens, hex_ones, hex_lives, SEG0, SEG0, SEG3); end
    // IDLE ignores win and collision.
    win = 4'b1111;
    collision = 1'b1;
    tick(1);
    win = 4'b0000;
    collision = 1'b0;
    tick(1);
    checks++; if ({score_tens, score_ones, lives, round_reset} !== {8'h00, 4'd3, 1'b1}) begin errors++; $display("[TB] FAIL idle_ignore: got %h/%0d/%b want 00/3/1", {score_tens, score_ones}, lives, round_reset); end
  endtask

  task automatic test_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checks++; if (round_reset !== 1'b0) begin errors++; $display("[TB] FAIL start_rr: got %b want 0", round_reset); end
    checks++; if ({score_tens, score_ones, lives} !== {8'h00, 4'd3}) begin errors++; $display("[TB] FAIL start_state: got %h/%0d want 00/3", {score_tens, score_ones}, lives); end
    checks++; if (hex_lives !== SEG3) begin errors++; $display("[TB] FAIL start_hex_lives: got %b want %b", hex_lives, SEG3); end
  endtask

  task automatic test_win();
    win = 4'b0100;
    tick(1);
    checks++; if ({score_tens, score_ones} !== 8'h01) begin errors++; $display("[TB] FAIL win_score: got %h want 01", {score_tens, score_ones}); end
    checks++; if (round_reset !== 1'b1) begin errors++; $display("[TB] FAIL win_rr_c1: got %b want 1", round_reset); end
    // Stale pulses during the end delay must not score.
    for (int k = 2; k <= 4; k++) begin
      win = 4'b1111;
      tick(1);
      checks++; if (round_reset !== 1'b1) begin errors++; $display("[TB] FAIL win_rr_c%0d: got %b want 1", k, round_reset); end
      checks++; if ({score_tens, score_ones} !== 8'h01) begin errors++; $display("[TB] FAIL win_stale_c%0d: got %h want 01", k, {score_tens, score_ones}); end
    end
    win = 4'b0000;
    tick(1);
    checks++; if (round_reset !== 1'b0) begin errors++; $display("[TB] FAIL win_rr_end: got %b want 0", round_reset); end
    checks++; if (hex_ones !== SEG1) begin errors++; $display("[TB] FAIL win_hex_ones: got %b want %b", hex_ones, SEG1); end
  endtask

  task automatic test_win_collision();
    win = 4'b0001;
    collision = 1'b1;
    tick(1);
    win = 4'b0000;
    collision = 1'b0;
    checks++; if ({score_tens, score_ones} !== 8'h02) begin errors++; $display("[TB] FAIL wincol_score: got %h want 02", {score_tens, score_ones}); end
    checks++; if (lives !== 4'd3) begin errors++; $display("[TB] FAIL wincol_lives: got %0d want 3", lives); end
    tick(4);
    checks++; if (round_reset !== 1'b0) begin errors++; $display("[TB] FAIL wincol_back_play: got %b want 0", round_reset); end
  endtask

  task automatic test_bcd_carry();
    // The score is 02 here; seven more wins reach 09.
    repeat (7) score_win();
    checks++; if ({score_tens, score_ones} !== 8'h09) begin errors++; $display("[TB] FAIL bcd_09: got %h want 09", {score_tens, score_ones}); end
    checks++; if (hex_ones !== SEG9) begin errors++; $display("[TB] FAIL bcd_hex9: got %b want %b", hex_ones, SEG9); end
    score_win();
    checks++; if ({score_tens, score_ones} !== 8'h10) begin errors++; $display("[TB] FAIL bcd_carry: got %h want 10", {score_tens, score_ones}); end
    checks++; if ({hex_tens, hex_ones} !== {SEG1, SEG0}) begin errors++; $display("[TB] FAIL bcd_hex10: got %b %b want %b %b", hex_tens, hex_ones, SEG1, SEG0); end
    repeat (89) score_win();
    checks++; if ({score_tens, score_ones} !== 8'h99) begin errors++; $display("[TB] FAIL bcd_99: got %h want 99", {score_tens, score_ones}); end
    win = 4'b1000;
    tick(1);
    win = 4'b0000;
    checks++; if ({score_tens, score_ones} !== 8'h99) begin errors++; $display("[TB] FAIL bcd_saturate: got %h want 99", {score_tens, score_ones}); end
    checks++; if (round_reset !== 1'b1) begin errors++; $display("[TB] FAIL bcd_sat_rr: got %b want 1", round_reset); end
    tick(4);
  endtask

  task automatic test_lives();
    hit_car();
    checks++; if (lives !== 4'd2) begin errors++; $display("[TB] FAIL lives_2: got %0d want 2", lives); end
    checks++; if (hex_lives !== SEG2) begin errors++; $display("[TB] FAIL lives_hex2: got %b want %b", hex_lives, SEG2); end
    checks++; if (round_reset !== 1'b0) begin errors++; $display("[TB] FAIL lives_play: got %b want 0", round_reset); end
    hit_car();
    checks++; if (lives !== 4'd1) begin errors++; $display("[TB] FAIL lives_1: got %0d want 1", lives); end
    collision = 1'b1;
    tick(1);
    collision = 1'b0;
    checks++; if ({lives, game_over, round_reset} !== {4'd0, 1'b1, 1'b1}) begin errors++; $display("[TB] FAIL lives_over: got %0d/%b/%b want 0/1/1", lives, game_over, round_reset); end
    win = 4'b1111;
    tick(2);
    win = 4'b0000;
    tick(6);
    checks++; if ({score_tens, score_ones, lives, game_over, round_reset} !== {8'h99, 4'd0, 1'b1, 1'b1}) begin errors++; $display("[TB] FAIL over_frozen: got %h/%0d/%b/%b want 99/0/1/1", {score_tens, score_ones}, lives, game_over, round_reset); end
  endtask

  task automatic test_reset_held_start();
    // Assert start and reset together in GAME_OVER, and keep start high afterwards.
    start = 1'b1;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);
    checks++; if ({score_tens, score_ones, lives, game_over, round_reset} !== {8'h00, 4'd3, 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL held_start_idle: got %h/%0d/%b/%b want 00/3/0/1", {score_tens, score_ones}, lives, game_over, round_reset); end
    start = 1'b0;
    tick(1);
    checks++; if (round_reset !== 1'b1) begin errors++; $display("[TB] FAIL held_release: got %b want 1", round_reset); end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checks++; if (round_reset !== 1'b0) begin errors++; $display("[TB] FAIL held_fresh_edge: got %b want 0", round_reset); end
  endtask

  task automatic test_restart();
    repeat (2) hit_car();
    collision = 1'b1;
    tick(1);
    collision = 1'b0;
    tick(2);
    checks++; if (game_over !== 1'b1) begin errors++; $display("[TB] FAIL restart_pre_over: got %b want 1", game_over); end
    start = 1'b1;
    tick(1);
    checks++; if ({score_tens, score_ones, lives, game_over} !== {8'h00, 4'd3, 1'b0}) begin errors++; $display("[TB] FAIL restart_state: got %h/%0d/%b want 00/3/0", {score_tens, score_ones}, lives, game_over); end
    checks++; if (round_reset !== 1'b1) begin errors++; $display("[TB] FAIL restart_rr_c1: got %b want 1", round_reset); end
    for (int k = 2; k <= 4; k++) begin
      tick(1);
      checks++; if (round_reset !== 1'b1) begin errors++; $display("[TB] FAIL restart_rr_c%0d: got %b want 1", k, round_reset); end
    end
    tick(1);
    start = 1'b0;
    checks++; if (round_reset !== 1'b0) begin errors++; $display("[TB] FAIL restart_play: got %b want 0", round_reset); end
  endtask

  task automatic test_back_to_back();
    // Score two rounds back to back to confirm a second win lands in the next PLAY.
    win = 4'b0001;
    tick(1);
    win = 4'b0000;
    tick(4);
    win = 4'b0110;
    tick(1);
    win = 4'b0000;
    checks++; if ({score_tens, score_ones} !== 8'h02) begin errors++; $display("[TB] FAIL b2b_score: got %h want 02", {score_tens, score_ones}); end
  endtask

  task automatic test_reset_mid_delay();
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++; if ({score_tens, score_ones, lives, game_over, round_reset} !== {8'h00, 4'd3, 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL mid_reset_state: got %h/%0d/%b/%b want 00/3/0/1", {score_tens, score_ones}, lives, game_over, round_reset); end
    tick(6);
    checks++; if (round_reset !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_idle: got %b want 1", round_reset); end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    win       = 4'b0000;
    collision = 1'b0;
    tick(2);
    $display("[TB] starting directed tests");
    test_reset();
    test_start();
    test_win();
    test_win_collision();
    test_bcd_carry();
    test_lives();
    test_reset_held_start();
    test_restart();
    test_back_to_back();
    test_reset_mid_delay();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
